// File: rtl/issue_select_multi_if.sv
// Packet format and the grouped request/issue bus of the issue-select stage.
// A packet carries a valid bit, a 2-bit functional-unit class and a data payload.
package issue_select_multi_pkg;
  localparam int DATA_W = 8;
  localparam logic [1:0] FU_ALU  = 2'd0;
  localparam logic [1:0] FU_MULT = 2'd1;
  localparam logic [1:0] FU_MEM  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [1:0]        func_unit;
    logic [DATA_W-1:0] data;
  } rs_is_packet_t;
endpackage

interface issue_select_multi_if #(
  parameter int RS_SIZE  = 16,
  parameter int NUM_ALU  = 2,
  parameter int NUM_MULT = 1,
  parameter int NUM_MEM  = 1
);
  import issue_select_multi_pkg::*;

  logic                                flush;
  logic          [RS_SIZE-1:0]         req;
  rs_is_packet_t [RS_SIZE-1:0]         rs_is_packet_in;
  logic          [NUM_ALU-1:0]         alu_stall_in;
  logic          [NUM_MULT-1:0]        mult_stall_in;
  logic          [NUM_MEM-1:0]         mem_stall_in;
  rs_is_packet_t [NUM_ALU-1:0]         rs_is_alu_out;
  logic          [NUM_ALU-1:0]         rs_is_alu_vld;
  rs_is_packet_t [NUM_MULT-1:0]        rs_is_mult_out;
  logic          [NUM_MULT-1:0]        rs_is_mult_vld;
  rs_is_packet_t [NUM_MEM-1:0]         rs_is_mem_out;
  logic          [NUM_MEM-1:0]         rs_is_mem_vld;
  logic          [RS_SIZE-1:0]         free;

  modport master (
    output flush, req, rs_is_packet_in, alu_stall_in, mult_stall_in, mem_stall_in,
    input  rs_is_alu_out, rs_is_alu_vld, rs_is_mult_out, rs_is_mult_vld,
           rs_is_mem_out, rs_is_mem_vld, free
  );

  modport slave (
    input  flush, req, rs_is_packet_in, alu_stall_in, mult_stall_in, mem_stall_in,
    output rs_is_alu_out, rs_is_alu_vld, rs_is_mult_out, rs_is_mult_vld,
           rs_is_mem_out, rs_is_mem_vld, free
  );
endinterface

// File: rtl/issue_select_multi.sv
// Issue select: per-class rotating-priority pick of ready RS entries into
// registered issue channels, with per-channel stall/hold and flush.
module issue_select_class
  import issue_select_multi_pkg::*;
#(
  parameter int         RS_SIZE = 16,
  parameter int         NCH     = 1,
  parameter logic [1:0] FU      = FU_ALU
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush_i,
  input  logic          [RS_SIZE-1:0] req_i,
  input  rs_is_packet_t [RS_SIZE-1:0] pkt_i,
  input  logic          [NCH-1:0]     stall_i,
  output rs_is_packet_t [NCH-1:0]     pkt_o,
  output logic          [NCH-1:0]     vld_o,
  output logic          [RS_SIZE-1:0] gnt_o
);
  localparam int PW = $clog2(RS_SIZE);

  logic          [PW-1:0]          ptr_q, ptr_d;
  logic          [NCH-1:0]         vld_q, vld_d, load_en;
  rs_is_packet_t [NCH-1:0]         pkt_q, pkt_d;
  logic          [RS_SIZE-1:0]     cand;
  logic          [NCH-1:0][PW-1:0] pick;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++)
      cand[i] = req_i[i] & pkt_i[i].valid & (pkt_i[i].func_unit == FU);
  end

  assign load_en = ~vld_q | ~stall_i;

  // k-th candidate in rotated order goes to the k-th enabled channel.
  always_comb begin
    int            nen, k, r;
    logic [PW-1:0] idx;
    nen   = 0;
    k     = 0;
    r     = 0;
    idx   = '0;
    gnt_o = '0;
    pick  = '0;
    ptr_d = ptr_q;
    vld_d = vld_q;
    pkt_d = pkt_q;
    for (int c = 0; c < NCH; c++)
      if (load_en[c]) nen++;
    if (reset && !flush_i) begin
      for (int o = 0; o < RS_SIZE; o++) begin
        idx = ptr_q + PW'(o);
        if (cand[idx] && k < nen) begin
          gnt_o[idx] = 1'b1;
          pick[k]    = idx;
          k++;
          ptr_d      = idx + PW'(1);
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (flush_i) begin
        vld_d[c] = 1'b0;
      end else if (load_en[c]) begin
        if (r < k) begin
          vld_d[c] = 1'b1;
          pkt_d[c] = pkt_i[pick[r]];
        end else begin
          vld_d[c] = 1'b0;
        end
        r++;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      vld_q <= '0;
      pkt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      pkt_q <= pkt_d;
    end
  end

  assign pkt_o = pkt_q;
  assign vld_o = vld_q;
endmodule

module issue_select_multi
  import issue_select_multi_pkg::*;
#(
  parameter int RS_SIZE  = 16,
  parameter int NUM_ALU  = 2,
  parameter int NUM_MULT = 1,
  parameter int NUM_MEM  = 1
) (
  input  logic               clock,
  input  logic               reset,
  issue_select_multi_if.slave bus
);
  logic [RS_SIZE-1:0] gnt_alu, gnt_mult, gnt_mem;

  issue_select_class #(.RS_SIZE(RS_SIZE), .NCH(NUM_ALU), .FU(FU_ALU)) u_alu (
    .clock   (clock),
    .reset   (reset),
    .flush_i (bus.flush),
    .req_i   (bus.req),
    .pkt_i   (bus.rs_is_packet_in),
    .stall_i (bus.alu_stall_in),
    .pkt_o   (bus.rs_is_alu_out),
    .vld_o   (bus.rs_is_alu_vld),
    .gnt_o   (gnt_alu)
  );

  issue_select_class #(.RS_SIZE(RS_SIZE), .NCH(NUM_MULT), .FU(FU_MULT)) u_mult (
    .clock   (clock),
    .reset   (reset),
    .flush_i (bus.flush),
    .req_i   (bus.req),
    .pkt_i   (bus.rs_is_packet_in),
    .stall_i (bus.mult_stall_in),
    .pkt_o   (bus.rs_is_mult_out),
    .vld_o   (bus.rs_is_mult_vld),
    .gnt_o   (gnt_mult)
  );

  issue_select_class #(.RS_SIZE(RS_SIZE), .NCH(NUM_MEM), .FU(FU_MEM)) u_mem (
    .clock   (clock),
    .reset   (reset),
    .flush_i (bus.flush),
    .req_i   (bus.req),
    .pkt_i   (bus.rs_is_packet_in),
    .stall_i (bus.mem_stall_in),
    .pkt_o   (bus.rs_is_mem_out),
    .vld_o   (bus.rs_is_mem_vld),
    .gnt_o   (gnt_mem)
  );

  // Classes are disjoint, so the OR never merges two grants of one entry.
  assign bus.free = gnt_alu | gnt_mult | gnt_mem;
endmodule

// File: tb/tb_issue_select_multi.sv
// Bench for issue_select_multi: directed scenarios plus a randomized run
// against a queue-based reference model of the selection rules.
module tb_issue_select_multi;
  import issue_select_multi_pkg::*;

  localparam int RS   = 16;
  localparam int NA   = 2;
  localparam int NMU  = 1;
  localparam int NME  = 1;
  localparam int MAXC = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  issue_select_multi_if #(.RS_SIZE(RS), .NUM_ALU(NA), .NUM_MULT(NMU), .NUM_MEM(NME)) bus ();

  issue_select_multi #(.RS_SIZE(RS), .NUM_ALU(NA), .NUM_MULT(NMU), .NUM_MEM(NME)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // reference model state
  logic          m_vld [3][MAXC];
  rs_is_packet_t m_pkt [3][MAXC];
  int            m_ptr [3];
  logic          n_vld [3][MAXC];
  rs_is_packet_t n_pkt [3][MAXC];
  int            n_ptr [3];
  logic [RS-1:0] m_free;

  function automatic rs_is_packet_t mk(logic v, logic [1:0] fu, int d);
    rs_is_packet_t p;
    p.valid     = v;
    p.func_unit = fu;
    p.data      = DATA_W'(d);
    return p;
  endfunction

  function automatic int nch(int cls);
    return (cls == 0) ? NA : (cls == 1) ? NMU : NME;
  endfunction

  function automatic logic [1:0] fu_of(int cls);
    return (cls == 0) ? FU_ALU : (cls == 1) ? FU_MULT : FU_MEM;
  endfunction

  function automatic logic stall_of(int cls, int ch);
    case (cls)
      0:       return bus.alu_stall_in[ch];
      1:       return bus.mult_stall_in[ch];
      default: return bus.mem_stall_in[ch];
    endcase
  endfunction

  function automatic logic dut_vld(int cls, int ch);
    case (cls)
      0:       return bus.rs_is_alu_vld[ch];
      1:       return bus.rs_is_mult_vld[ch];
      default: return bus.rs_is_mem_vld[ch];
    endcase
  endfunction

  function automatic rs_is_packet_t dut_pkt(int cls, int ch);
    case (cls)
      0:       return bus.rs_is_alu_out[ch];
      1:       return bus.rs_is_mult_out[ch];
      default: return bus.rs_is_mem_out[ch];
    endcase
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_inputs;
    bus.flush         = 1'b0;
    bus.req           = '0;
    bus.alu_stall_in  = '0;
    bus.mult_stall_in = '0;
    bus.mem_stall_in  = '0;
    for (int i = 0; i < RS; i++) bus.rs_is_packet_in[i] = '0;
  endtask

  task automatic all_fu(logic [1:0] fu);
    for (int i = 0; i < RS; i++) bus.rs_is_packet_in[i] = mk(1'b1, fu, i);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      m_ptr[c] = 0;
      for (int h = 0; h < MAXC; h++) begin
        m_vld[c][h] = 1'b0;
        m_pkt[c][h] = '0;
      end
    end
  endtask

  // Model: list enabled channels and candidates in rotated order, pair them up.
  task automatic model_eval;
    int en[$];
    int cands[$];
    int ng;
    int e;
    m_free = '0;
    for (int cls = 0; cls < 3; cls++) begin
      en.delete();
      cands.delete();
      n_ptr[cls] = m_ptr[cls];
      for (int ch = 0; ch < MAXC; ch++) begin
        n_vld[cls][ch] = m_vld[cls][ch];
        n_pkt[cls][ch] = m_pkt[cls][ch];
      end
      for (int ch = 0; ch < nch(cls); ch++) begin
        if (bus.flush) begin
          n_vld[cls][ch] = 1'b0;
        end else if (!m_vld[cls][ch] || !stall_of(cls, ch)) begin
          en.push_back(ch);
          n_vld[cls][ch] = 1'b0;
        end
      end
      if (!bus.flush) begin
        for (int o = 0; o < RS; o++) begin
          e = (m_ptr[cls] + o) % RS;
          if (bus.req[e] && bus.rs_is_packet_in[e].valid &&
              bus.rs_is_packet_in[e].func_unit == fu_of(cls))
            cands.push_back(e);
        end
      end
      ng = (en.size() < cands.size()) ? en.size() : cands.size();
      for (int g = 0; g < ng; g++) begin
        n_vld[cls][en[g]] = 1'b1;
        n_pkt[cls][en[g]] = bus.rs_is_packet_in[cands[g]];
        m_free[cands[g]]  = 1'b1;
        n_ptr[cls]        = (cands[g] + 1) % RS;
      end
    end
  endtask

  task automatic model_commit;
    for (int cls = 0; cls < 3; cls++) begin
      m_ptr[cls] = n_ptr[cls];
      for (int ch = 0; ch < MAXC; ch++) begin
        m_vld[cls][ch] = n_vld[cls][ch];
        m_pkt[cls][ch] = n_pkt[cls][ch];
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    all_fu(FU_ALU);
    bus.req = '1;
    tick();
    checks++;
    if (bus.rs_is_alu_vld !== 2'b11) begin
      fails++;
      $display("FAIL reset_pre_vld got=%b exp=11", bus.rs_is_alu_vld);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.rs_is_alu_vld, bus.rs_is_mult_vld, bus.rs_is_mem_vld} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_async_vld got=%b exp=0000",
               {bus.rs_is_alu_vld, bus.rs_is_mult_vld, bus.rs_is_mem_vld});
    end
    checks++;
    if (bus.rs_is_alu_out !== '0) begin
      fails++;
      $display("FAIL reset_async_pkt got=%h exp=0", bus.rs_is_alu_out);
    end
    checks++;
    if (bus.free !== 16'h0000) begin
      fails++;
      $display("FAIL reset_free got=%h exp=0000", bus.free);
    end
    @(posedge clock);
    #1;
    reset   = 1'b1;
    bus.req = '0;
    settle();
    checks++;
    if (bus.free !== 16'h0000) begin
      fails++;
      $display("FAIL reset_idle_free got=%h exp=0000", bus.free);
    end
    tick();
    checks++;
    if ({bus.rs_is_alu_vld, bus.rs_is_mult_vld, bus.rs_is_mem_vld} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_idle_vld got=%b exp=0000",
               {bus.rs_is_alu_vld, bus.rs_is_mult_vld, bus.rs_is_mem_vld});
    end
  endtask

  task automatic test_alu_burst;
    do_reset();
    all_fu(FU_ALU);
    bus.req = '1;
    settle();
    checks++;
    if (bus.free !== 16'h0003) begin
      fails++;
      $display("FAIL burst_free0 got=%h exp=0003", bus.free);
    end
    tick();
    checks++;
    if (bus.rs_is_alu_vld !== 2'b11 || bus.rs_is_alu_out[0] !== mk(1'b1, FU_ALU, 0) ||
        bus.rs_is_alu_out[1] !== mk(1'b1, FU_ALU, 1)) begin
      fails++;
      $display("FAIL burst_out0 vld=%b d0=%0d d1=%0d exp vld=11 d0=0 d1=1",
               bus.rs_is_alu_vld, bus.rs_is_alu_out[0].data, bus.rs_is_alu_out[1].data);
    end
    checks++;
    if (bus.free !== 16'h000C) begin
      fails++;
      $display("FAIL burst_free1 got=%h exp=000c", bus.free);
    end
    tick();
    checks++;
    if (bus.rs_is_alu_out[0].data !== 8'd2 || bus.rs_is_alu_out[1].data !== 8'd3) begin
      fails++;
      $display("FAIL burst_out1 d0=%0d d1=%0d exp d0=2 d1=3",
               bus.rs_is_alu_out[0].data, bus.rs_is_alu_out[1].data);
    end
  endtask

  task automatic test_stall_hold;
    do_reset();
    all_fu(FU_ALU);
    bus.req = 16'hC000;
    settle();
    checks++;
    if (bus.free !== 16'hC000) begin
      fails++;
      $display("FAIL stall_setup_free got=%h exp=c000", bus.free);
    end
    tick();
    bus.req          = '1;
    bus.alu_stall_in = 2'b10;
    settle();
    checks++;
    if (bus.free !== 16'h0001) begin
      fails++;
      $display("FAIL stall_free got=%h exp=0001", bus.free);
    end
    tick();
    checks++;
    if (bus.rs_is_alu_vld !== 2'b11 || bus.rs_is_alu_out[0] !== mk(1'b1, FU_ALU, 0) ||
        bus.rs_is_alu_out[1] !== mk(1'b1, FU_ALU, 15)) begin
      fails++;
      $display("FAIL stall_hold vld=%b d0=%0d d1=%0d exp vld=11 d0=0 d1=15",
               bus.rs_is_alu_vld, bus.rs_is_alu_out[0].data, bus.rs_is_alu_out[1].data);
    end
  endtask

  task automatic test_mixed;
    do_reset();
    all_fu(FU_ALU);
    bus.rs_is_packet_in[0] = mk(1'b1, FU_MULT, 0);
    bus.req = '1;
    settle();
    checks++;
    if (bus.free !== 16'h0007) begin
      fails++;
      $display("FAIL mixed_free got=%h exp=0007", bus.free);
    end
    tick();
    checks++;
    if (bus.rs_is_mult_vld !== 1'b1 || bus.rs_is_mult_out[0] !== mk(1'b1, FU_MULT, 0) ||
        bus.rs_is_alu_out[0].data !== 8'd1 || bus.rs_is_alu_out[1].data !== 8'd2 ||
        bus.rs_is_alu_vld !== 2'b11 || bus.rs_is_mem_vld !== 1'b0) begin
      fails++;
      $display("FAIL mixed_out mult=%b/%0d alu=%b/%0d/%0d mem=%b exp 1/0 11/1/2 0",
               bus.rs_is_mult_vld, bus.rs_is_mult_out[0].data, bus.rs_is_alu_vld,
               bus.rs_is_alu_out[0].data, bus.rs_is_alu_out[1].data, bus.rs_is_mem_vld);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    all_fu(FU_ALU);
    bus.req = 16'h4000;
    tick();
    checks++;
    if (bus.rs_is_alu_vld !== 2'b01 || bus.rs_is_alu_out[0].data !== 8'd14) begin
      fails++;
      $display("FAIL wrap_setup vld=%b d0=%0d exp vld=01 d0=14",
               bus.rs_is_alu_vld, bus.rs_is_alu_out[0].data);
    end
    for (int i = 1; i < 15; i++) bus.rs_is_packet_in[i] = mk(1'b1, 2'd3, i);
    bus.req = '1;
    settle();
    checks++;
    if (bus.free !== 16'h8001) begin
      fails++;
      $display("FAIL wrap_free got=%h exp=8001", bus.free);
    end
    tick();
    checks++;
    if (bus.rs_is_alu_out[0].data !== 8'd15 || bus.rs_is_alu_out[1].data !== 8'd0 ||
        bus.rs_is_alu_vld !== 2'b11) begin
      fails++;
      $display("FAIL wrap_out vld=%b d0=%0d d1=%0d exp vld=11 d0=15 d1=0",
               bus.rs_is_alu_vld, bus.rs_is_alu_out[0].data, bus.rs_is_alu_out[1].data);
    end
    all_fu(FU_ALU);
    settle();
    checks++;
    if (bus.free !== 16'h0006) begin
      fails++;
      $display("FAIL wrap_ptr got=%h exp=0006", bus.free);
    end
  endtask

  task automatic test_flush;
    do_reset();
    all_fu(FU_ALU);
    bus.rs_is_packet_in[2] = mk(1'b1, FU_MULT, 2);
    bus.rs_is_packet_in[3] = mk(1'b1, FU_MEM, 3);
    bus.req = '1;
    settle();
    checks++;
    if (bus.free !== 16'h000F) begin
      fails++;
      $display("FAIL flush_setup_free got=%h exp=000f", bus.free);
    end
    tick();
    checks++;
    if ({bus.rs_is_alu_vld, bus.rs_is_mult_vld, bus.rs_is_mem_vld} !== 4'b1111 ||
        bus.rs_is_mult_out[0].data !== 8'd2 || bus.rs_is_mem_out[0].data !== 8'd3) begin
      fails++;
      $display("FAIL flush_setup_out vld=%b mult=%0d mem=%0d exp vld=1111 mult=2 mem=3",
               {bus.rs_is_alu_vld, bus.rs_is_mult_vld, bus.rs_is_mem_vld},
               bus.rs_is_mult_out[0].data, bus.rs_is_mem_out[0].data);
    end
    bus.flush         = 1'b1;
    bus.alu_stall_in  = '1;
    bus.mult_stall_in = '1;
    bus.mem_stall_in  = '1;
    settle();
    checks++;
    if (bus.free !== 16'h0000) begin
      fails++;
      $display("FAIL flush_free got=%h exp=0000", bus.free);
    end
    tick();
    checks++;
    if ({bus.rs_is_alu_vld, bus.rs_is_mult_vld, bus.rs_is_mem_vld} !== 4'b0000) begin
      fails++;
      $display("FAIL flush_vld got=%b exp=0000",
               {bus.rs_is_alu_vld, bus.rs_is_mult_vld, bus.rs_is_mem_vld});
    end
    bus.flush         = 1'b0;
    bus.alu_stall_in  = '0;
    bus.mult_stall_in = '0;
    bus.mem_stall_in  = '0;
    all_fu(FU_ALU);
    settle();
    checks++;
    if (bus.free !== 16'h000C) begin
      fails++;
      $display("FAIL flush_alu_ptr got=%h exp=000c", bus.free);
    end
    all_fu(FU_MULT);
    settle();
    checks++;
    if (bus.free !== 16'h0008) begin
      fails++;
      $display("FAIL flush_mult_ptr got=%h exp=0008", bus.free);
    end
    all_fu(FU_MEM);
    settle();
    checks++;
    if (bus.free !== 16'h0010) begin
      fails++;
      $display("FAIL flush_mem_ptr got=%h exp=0010", bus.free);
    end
  endtask

  task automatic test_random;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.flush         = ($urandom_range(15) == 0);
      bus.req           = RS'($urandom);
      bus.alu_stall_in  = NA'($urandom);
      bus.mult_stall_in = NMU'($urandom);
      bus.mem_stall_in  = NME'($urandom);
      for (int i = 0; i < RS; i++)
        bus.rs_is_packet_in[i] = mk($urandom_range(7) != 0, 2'($urandom_range(3)),
                                    int'($urandom_range(255)));
      model_eval();
      settle();
      checks++;
      if (bus.free !== m_free) begin
        fails++;
        $display("FAIL rand_free cyc=%0d got=%h exp=%h", cyc, bus.free, m_free);
      end
      tick();
      model_commit();
      for (int cls = 0; cls < 3; cls++) begin
        for (int ch = 0; ch < nch(cls); ch++) begin
          checks++;
          if (dut_vld(cls, ch) !== m_vld[cls][ch]) begin
            fails++;
            $display("FAIL rand_vld cyc=%0d cls=%0d ch=%0d got=%b exp=%b",
                     cyc, cls, ch, dut_vld(cls, ch), m_vld[cls][ch]);
          end
          if (m_vld[cls][ch]) begin
            checks++;
            if (dut_pkt(cls, ch) !== m_pkt[cls][ch]) begin
              fails++;
              $display("FAIL rand_pkt cyc=%0d cls=%0d ch=%0d got=%h exp=%h",
                       cyc, cls, ch, dut_pkt(cls, ch), m_pkt[cls][ch]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_burst();
    test_stall_hold();
    test_mixed();
    test_wrap();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/issue_select_multi.md
Name: issue_select_multi

Overview:
- Parametrised issue stage between the reservation station and the functional units.
- Each cycle it picks ready RS entries per FU class (ALU, MULT, MEM) using per-class rotating priority.
- Each pick is loaded into a per-channel issue register, and the granted RS entries are reported back through `free`.
- Supports any number of channels per class, per-channel stall with hold, and flush.

Parameters:
- RS_SIZE, 16, number of RS entries presented (power of two, ≥2)
- NUM_ALU, 2, number of ALU issue channels (≥1)
- NUM_MULT, 1, number of MULT issue channels (≥1)
- NUM_MEM, 1, number of MEM issue channels (≥1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all issue registers
- req  in  RS_SIZE  entry i is ready to issue
- rs_is_packet_in  in  RS_SIZE x RS_IS_PACKET  entry contents; func_unit selects class
- alu_stall_in  in  NUM_ALU  ALU channel c cannot accept this cycle
- mult_stall_in  in  NUM_MULT  per-channel stall
- mem_stall_in  in  NUM_MEM  per-channel stall
- rs_is_alu_out  out  NUM_ALU x RS_IS_PACKET  registered ALU issue packets
- rs_is_alu_vld  out  NUM_ALU  ALU packet valid
- rs_is_mult_out  out  NUM_MULT x RS_IS_PACKET  registered MULT issue packets
- rs_is_mult_vld  out  NUM_MULT  MULT packet valid
- rs_is_mem_out  out  NUM_MEM x RS_IS_PACKET  registered MEM issue packets
- rs_is_mem_vld  out  NUM_MEM  MEM packet valid
- free  out  RS_SIZE  combinational; entry i granted this cycle

Behaviour:
- Candidate: entry i is a candidate when req[i] and rs_is_packet_in[i].valid are both 1. Its class is taken from func_unit.
- Channel load-enable: load_en[c] = !vld[c] | !stall[c].
  - A channel with vld=1 and stall=1 holds its packet and vld bit-stable.
- Per-class state: one pointer ptr_k of width $clog2(RS_SIZE), reset 0.
- Selection within a class:
  - Scan entries in order ptr_k, ptr_k+1, … (mod RS_SIZE).
  - Assign the first candidate to the lowest-index enabled channel of that class, the next candidate to the next enabled channel, and so on.
  - The number of grants equals min(candidates, enabled channels).
- Grant effects:
  - free[i]=1 in the same cycle entry i is granted.
  - At the next edge the channel register captures the packet and sets vld=1.
- Enabled but ungranted channel: vld←0 at the next edge; the packet contents are don't-care.
- Pointer update: if the class granted anything, ptr_k ← (index of last granted entry + 1) mod RS_SIZE. Otherwise ptr_k holds.
- Latency: grant-to-output is 1 cycle; there is no combinational path from req to any *_out.
- Each entry is granted to at most one channel per cycle. free is one-hot-per-grant; total popcount ≤ NUM_ALU+NUM_MULT+NUM_MEM.
- Stall is applied before selection: a stalled valid channel is excluded from the grant count.
- flush=1:
  - free=0 and no grants that cycle.
  - All vld←0 at the next edge, stalled channels included.
  - Pointers hold.
- reset low (any time):
  - Immediately all vld=0, all *_out packets=0, pointers=0.
  - free=0 while reset is low.
- func_unit values outside ALU/MULT/MEM: the entry is never granted.

Test Plan:
1. Reset: drive reset low mid-operation with rs_is_alu_vld=2'b11 -> vld=0 immediately, without waiting for an edge. Release reset and hold req=0 -> free=0, all vld stay 0.
2. All-ALU burst, req=16'hFFFF, no stalls -> cycle0 free=16'h0003, next edge alu0=entry0, alu1=entry1. Cycle1 with the same inputs -> free=16'h000C (ptr=2).
3. Stall hold: alu1 vld=1 and alu_stall_in=2'b10, req=16'hFFFF all ALU, ptr=0 -> free=16'h0001, alu0 gets entry0, alu1 packet and vld unchanged.
4. Mixed classes: entry0 MULT, entries1-15 ALU, req=16'hFFFF, ptrs=0 -> free=16'h0007, mult0=entry0, alu0=entry1, alu1=entry2, mem vld=0.
5. Wrap-around: ALU ptr=15, only entries 15 and 0 are ALU candidates -> free=16'h8001, alu0=entry15, alu1=entry0, ptr becomes 1.
6. Flush: flush=1 with all channels valid and stalled, req=16'hFFFF -> free=0 that cycle, all vld=0 after the edge, pointers unchanged.
